alu_result_tracer: RTL and testbench
====================================

ALU_RESULT_TRACER -- requirements
Module: alu_result_tracer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the captured ALU result word.
REQ-002 SHALL have parameter DEPTH, default 8, trace FIFO depth in words (power of 2, >=2).
REQ-003 SHALL have parameter CHANGE_ONLY, default 1, 1 = capture only when the value differs from the last captured word.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port alu_result_i  input  DATA_WIDTH  processor ALU result, sampled each clk.
REQ-007 SHALL have port capture_en_i  input  1  1 = sampling enabled this cycle.
REQ-008 SHALL have port clear_i  input  1  synchronous flush of FIFO, serializer and overflow state.
REQ-009 SHALL have port tx_data_o  output  8  current trace byte.
REQ-010 SHALL have port tx_valid_o  output  1  tx_data_o valid.
REQ-011 SHALL have port tx_ready_i  input  1  sink accepts byte when tx_valid_o and tx_ready_i both 1 at a rising edge.
REQ-012 SHALL have port level_o  output  clog2(DEPTH)+1  words currently held in the FIFO.
REQ-013 SHALL have port overflow_o  output  1  sticky: at least one sample dropped since reset/clear.
REQ-014 SHALL have port drop_count_o  output  8  dropped-sample count, saturating at 255.

Function
REQ-015 Capture condition SHALL be: capture_en_i=1 AND (CHANGE_ONLY=0 OR alu_result_i != last_word), last_word = most recent accepted-or-dropped qualifying sample.
REQ-016 A qualifying sample SHALL be written to the FIFO at that edge if level_o<DEPTH, or if level_o=DEPTH and a pop occurs at the same edge.
REQ-017 A qualifying sample arriving when full with no simultaneous pop SHALL be dropped: overflow_o set, drop_count_o +1 (saturating at 255), FIFO unchanged.
REQ-018 last_word SHALL update on every qualifying sample, including dropped ones.
REQ-019 Serializer FSM SHALL have states IDLE, B0, B1, B2, B3.
REQ-020 IDLE with FIFO non-empty SHALL pop the head word into a shift register and go to B0 at the same edge; IDLE with empty FIFO stays IDLE.
REQ-021 tx_valid_o SHALL be 1 exactly in B0..B3; bytes little-endian: B0=[7:0], B1=[15:8], B2=[23:16], B3=[31:24].
REQ-022 Bn SHALL hold tx_data_o stable while tx_ready_i=0; on handshake advance B0->B1->B2->B3.
REQ-023 B3 on handshake SHALL, if FIFO non-empty, pop the next word and go to B0 at the same edge (no idle bubble), else go to IDLE.
REQ-024 Latency: sample written at edge E0 into an empty FIFO with FSM in IDLE SHALL give tx_valid_o=1 with its byte 0 after edge E1.
REQ-025 level_o SHALL reflect net push/pop per edge (simultaneous push and pop leaves it unchanged); pointers wrap modulo DEPTH.
REQ-026 clear_i=1 SHALL at that edge empty the FIFO, force FSM to IDLE (aborting a partly sent word), clear overflow_o and drop_count_o, set last_word to 0; clear_i has priority over capture and handshake in the same cycle.

Reset
REQ-027 While reset=0: FSM IDLE, FIFO empty, level_o=0, tx_valid_o=0, tx_data_o=0, overflow_o=0, drop_count_o=0, last_word=0.
REQ-028 Reset assertion mid-word SHALL discard the word; after reset release no byte is emitted until a new sample qualifies.
REQ-029 With CHANGE_ONLY=1, a first sample equal to 0 after reset/clear SHALL NOT be captured.

Verification
REQ-030 Single word: capture 0x12345678 once, tx_ready_i=1 -> bytes 0x78,0x56,0x34,0x12 on 4 consecutive edges, tx_valid_o first high one edge after capture, level_o back to 0.
REQ-031 Back-pressure: tx_ready_i=0 for 5 cycles during B1 -> tx_data_o held at 0x56, no byte lost or duplicated.
REQ-032 Overflow: tx_ready_i=0, 10 distinct samples with DEPTH=8 -> level_o=8 (FSM holds 1 extra word in shift register, so 9 stored), drop_count_o=1, overflow_o=1; then drain yields the first 9 words in order.
REQ-033 Full with simultaneous pop: level_o=8, handshake at B3 and new sample same edge -> sample accepted, level_o stays 8, drop_count_o unchanged.
REQ-034 CHANGE_ONLY: alu_result_i sequence 5,5,5,7,7,5 with capture_en_i=1 -> words 5,7,5 emitted; with capture_en_i=0 -> nothing emitted.
REQ-035 Abort: clear_i during B2, and separately reset=0 during B2 -> tx_valid_o 0 next edge (async for reset), level_o=0, overflow_o=0, next sample starts fresh at B0.

Source files
------------

// File: rtl/alu_result_tracer.sv
// Purpose: snoops the ALU result bus, queues qualifying words in a small FIFO and
//          streams each word out as four little-endian bytes over valid/ready.
// Latency: a word written at edge E0 into an empty FIFO shows byte 0 after E1.
// Backpressure: tx_ready_i=0 holds the current byte; when the FIFO is full new samples are dropped and counted.
//
// Ports:
//   clk, reset        - single rising-edge clock, async active-low reset
//   alu_result_i      - ALU result word, sampled every cycle
//   capture_en_i      - enables sampling this cycle
//   clear_i           - synchronous flush of FIFO, serializer and overflow state
//   tx_data_o/_valid_o/tx_ready_i - byte stream out
//   level_o           - words held in the FIFO (shift register not counted)
//   overflow_o        - sticky "a sample was dropped"
//   drop_count_o      - dropped-sample count, saturating at 255
module alu_result_tracer #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 8,
  parameter int CHANGE_ONLY = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        alu_result_i,
  input  logic                         capture_en_i,
  input  logic                         clear_i,
  output logic [7:0]                   tx_data_o,
  output logic                         tx_valid_o,
  input  logic                         tx_ready_i,
  output logic [$clog2(DEPTH):0]       level_o,
  output logic                         overflow_o,
  output logic [7:0]                   drop_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {IDLE, B0, B1, B2, B3} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         level;
  logic [DATA_WIDTH-1:0] last_word;
  logic [31:0]           shreg;
  logic                  tx_valid;
  logic                  overflow;
  logic [7:0]            drop_cnt;

  logic        fifo_empty;
  logic        fifo_full;
  logic        handshake;
  logic        pop;
  logic        qualify;
  logic        push;
  logic        drop;
  logic [31:0] head_word;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LW'(DEPTH));
  assign handshake  = tx_valid && tx_ready_i;

  // A word leaves the FIFO when the serializer is idle, or at the last byte's
  // handshake so back-to-back words stream without a bubble.
  assign pop = !clear_i && !fifo_empty &&
               ((state == IDLE) || ((state == B3) && handshake));

  assign qualify = capture_en_i &&
                   ((CHANGE_ONLY == 0) || (alu_result_i != last_word));

  // A full FIFO still accepts a sample if a slot frees up at the same edge.
  assign push = !clear_i && qualify && (!fifo_full || pop);
  assign drop = !clear_i && qualify && !push;

  assign head_word = 32'(mem[rd_ptr]);

  assign tx_data_o    = shreg[7:0];
  assign tx_valid_o   = tx_valid;
  assign level_o      = level;
  assign overflow_o   = overflow;
  assign drop_count_o = drop_cnt;

  // Storage array has no reset; validity is tracked by the pointers/level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= alu_result_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      last_word <= '0;
      shreg     <= '0;
      tx_valid  <= 1'b0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else if (clear_i) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      last_word <= '0;
      shreg     <= '0;
      tx_valid  <= 1'b0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      // Dropped samples still move last_word so a repeated value is not
      // re-attempted once space frees up.
      if (qualify) begin
        last_word <= alu_result_i;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (pop) begin
            shreg    <= head_word;
            tx_valid <= 1'b1;
            state    <= B0;
          end
        end
        B0: begin
          if (handshake) begin
            shreg <= shreg >> 8;
            state <= B1;
          end
        end
        B1: begin
          if (handshake) begin
            shreg <= shreg >> 8;
            state <= B2;
          end
        end
        B2: begin
          if (handshake) begin
            shreg <= shreg >> 8;
            state <= B3;
          end
        end
        B3: begin
          if (handshake) begin
            if (pop) begin
              shreg <= head_word;
              state <= B0;
            end else begin
              shreg    <= '0;
              tx_valid <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: begin
          shreg    <= '0;
          tx_valid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_tracer.sv
module tb_alu_result_tracer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_result_i;
  logic        capture_en_i;
  logic        clear_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [3:0]  level_o;
  logic        overflow_o;
  logic [7:0]  drop_count_o;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb [$];

  typedef struct {
    logic        en;
    logic [31:0] d;
    logic        exp_cap;
  } vec_t;

  vec_t vecs [9];

  alu_result_tracer #(.DATA_WIDTH(32), .DEPTH(8), .CHANGE_ONLY(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_result_i (alu_result_i),
    .capture_en_i (capture_en_i),
    .clear_i      (clear_i),
    .tx_data_o    (tx_data_o),
    .tx_valid_o   (tx_valid_o),
    .tx_ready_i   (tx_ready_i),
    .level_o      (level_o),
    .overflow_o   (overflow_o),
    .drop_count_o (drop_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [31:0] w);
    sb.push_back(w[7:0]);
    sb.push_back(w[15:8]);
    sb.push_back(w[23:16]);
    sb.push_back(w[31:24]);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((tx_valid_o || level_o != 0) && n < 300) begin
      tick();
      n++;
    end
    check({name, "_drain_timeout"}, 32'(n >= 300), 32'd0);
    check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  // Byte monitor: a handshake completes at the coming rising edge.
  always @(negedge clk) begin
    if (reset && !clear_i && tx_valid_o && tx_ready_i) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL byte_unexpected: got %0h, expected no byte", tx_data_o);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (tx_data_o !== e) begin
          bad++;
          $display("FAIL byte_order: got %0h, expected %0h", tx_data_o, e);
        end
      end
    end
  end

  initial begin
    reset        = 1'b0;
    alu_result_i = '0;
    capture_en_i = 1'b0;
    clear_i      = 1'b0;
    tx_ready_i   = 1'b1;

    vecs[0] = '{1'b1, 32'd0, 1'b0};
    vecs[1] = '{1'b1, 32'd5, 1'b1};
    vecs[2] = '{1'b1, 32'd5, 1'b0};
    vecs[3] = '{1'b1, 32'd5, 1'b0};
    vecs[4] = '{1'b1, 32'd7, 1'b1};
    vecs[5] = '{1'b1, 32'd7, 1'b0};
    vecs[6] = '{1'b1, 32'd5, 1'b1};
    vecs[7] = '{1'b0, 32'd9, 1'b0};
    vecs[8] = '{1'b0, 32'd3, 1'b0};

    // Reset state
    tick();
    tick();
    check("rst_valid", 32'(tx_valid_o), 32'd0);
    check("rst_data", 32'(tx_data_o), 32'd0);
    check("rst_level", 32'(level_o), 32'd0);
    check("rst_overflow", 32'(overflow_o), 32'd0);
    check("rst_drop", 32'(drop_count_o), 32'd0);
    reset = 1'b1;
    tick();

    // Single word, ready held high
    capture_en_i = 1'b1;
    alu_result_i = 32'h12345678;
    expect_word(32'h12345678);
    tick();
    capture_en_i = 1'b0;
    check("single_valid_e0", 32'(tx_valid_o), 32'd0);
    check("single_level_e0", 32'(level_o), 32'd1);
    tick();
    check("single_valid_e1", 32'(tx_valid_o), 32'd1);
    check("single_byte0", 32'(tx_data_o), 32'h78);
    check("single_level_e1", 32'(level_o), 32'd0);
    tick();
    tick();
    tick();
    check("single_byte3", 32'(tx_data_o), 32'h12);
    tick();
    check("single_valid_end", 32'(tx_valid_o), 32'd0);
    check("single_sb_empty", 32'(sb.size()), 32'd0);

    // Back-pressure in B1
    capture_en_i = 1'b1;
    alu_result_i = 32'hCAFE5678;
    expect_word(32'hCAFE5678);
    tick();
    capture_en_i = 1'b0;
    tick();
    tick();
    tx_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_data", 32'(tx_data_o), 32'h56);
      check("bp_hold_valid", 32'(tx_valid_o), 32'd1);
      tick();
    end
    tx_ready_i = 1'b1;
    drain("bp");

    // Change-only filtering, table driven
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      capture_en_i = vecs[i].en;
      alu_result_i = vecs[i].d;
      if (vecs[i].exp_cap) expect_word(vecs[i].d);
      tick();
    end
    capture_en_i = 1'b0;
    drain("chg");
    check("chg_drop", 32'(drop_count_o), 32'd0);

    // Overflow with ready low, then full with simultaneous pop at B3
    tx_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      capture_en_i = 1'b1;
      alu_result_i = 32'h100 + 32'(i);
      if (i < 9) expect_word(32'h100 + 32'(i));
      tick();
    end
    capture_en_i = 1'b0;
    check("ovf_level", 32'(level_o), 32'd8);
    check("ovf_drop", 32'(drop_count_o), 32'd1);
    check("ovf_flag", 32'(overflow_o), 32'd1);
    check("ovf_valid", 32'(tx_valid_o), 32'd1);
    tx_ready_i = 1'b1;
    tick();
    tick();
    tick();
    check("full_b3_level", 32'(level_o), 32'd8);
    capture_en_i = 1'b1;
    alu_result_i = 32'h2000;
    expect_word(32'h2000);
    tick();
    capture_en_i = 1'b0;
    check("full_pop_level", 32'(level_o), 32'd8);
    check("full_pop_drop", 32'(drop_count_o), 32'd1);
    drain("ovf");

    // Clear during B2
    check("clr_pre_overflow", 32'(overflow_o), 32'd1);
    capture_en_i = 1'b1;
    alu_result_i = 32'hDEADBEEF;
    sb.push_back(8'hEF);
    sb.push_back(8'hBE);
    tick();
    capture_en_i = 1'b0;
    tick();
    tick();
    tick();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("clr_valid", 32'(tx_valid_o), 32'd0);
    check("clr_level", 32'(level_o), 32'd0);
    check("clr_overflow", 32'(overflow_o), 32'd0);
    check("clr_drop", 32'(drop_count_o), 32'd0);
    check("clr_sb", 32'(sb.size()), 32'd0);
    capture_en_i = 1'b1;
    alu_result_i = 32'h11223344;
    expect_word(32'h11223344);
    tick();
    capture_en_i = 1'b0;
    tick();
    check("clr_fresh_valid", 32'(tx_valid_o), 32'd1);
    check("clr_fresh_byte0", 32'(tx_data_o), 32'h44);
    drain("clr");

    // Asynchronous reset during B2
    capture_en_i = 1'b1;
    alu_result_i = 32'h55667788;
    sb.push_back(8'h88);
    sb.push_back(8'h77);
    tick();
    capture_en_i = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("arst_valid", 32'(tx_valid_o), 32'd0);
    check("arst_level", 32'(level_o), 32'd0);
    check("arst_data", 32'(tx_data_o), 32'd0);
    check("arst_sb", 32'(sb.size()), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    check("arst_quiet_valid", 32'(tx_valid_o), 32'd0);
    capture_en_i = 1'b1;
    alu_result_i = 32'd0;
    tick();
    tick();
    capture_en_i = 1'b0;
    check("zero_first_level", 32'(level_o), 32'd0);
    check("zero_first_valid", 32'(tx_valid_o), 32'd0);
    capture_en_i = 1'b1;
    alu_result_i = 32'hA5A5A5A5;
    expect_word(32'hA5A5A5A5);
    tick();
    capture_en_i = 1'b0;
    tick();
    check("arst_fresh_byte0", 32'(tx_data_o), 32'hA5);
    drain("arst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
